// File: rtl/spi_dma_wc_arb_if.sv
// Burst write bus between the write-channel arbiter and the BIU.
// Command (req/adr/len) plus per-beat write data handshake.
interface spi_dma_wc_arb_if #(
    parameter int AW = 32,
    parameter int BL = 4,
    parameter int DW = 32
);
    logic          biu_req;
    logic [AW-1:0] biu_adr;
    logic [BL:0]   biu_len;
    logic [DW-1:0] biu_wdat;
    logic          biu_ack;
    logic          biu_wval;

    modport master (
        output biu_req, biu_adr, biu_len, biu_wdat,
        input  biu_ack, biu_wval
    );

    modport slave (
        input  biu_req, biu_adr, biu_len, biu_wdat,
        output biu_ack, biu_wval
    );
endinterface

// File: rtl/spi_dma_wc_arb.sv
// Round-robin arbiter sharing one burst write master among N DMA
// write channels; the grant is held until the whole burst has moved.
module spi_dma_wc_arb #(
    parameter int N  = 4,
    parameter int AW = 32,
    parameter int BL = 4,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        ch_req,
    input  logic [N*AW-1:0]     ch_adr,
    input  logic [N*(BL+1)-1:0] ch_len,
    input  logic [N*DW-1:0]     ch_wdat,
    output logic [N-1:0]        ch_ack,
    output logic [N-1:0]        ch_wrd,
    output logic [N-1:0]        ch_gnt,
    spi_dma_wc_arb_if.master    biu
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = BL + 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic [IW-1:0] rr_nxt;
    logic          found;
    logic [LW-1:0] len_reg;
    logic [LW-1:0] beat_cnt;
    logic          ack_seen;
    logic          active;
    logic          ack_now;
    logic          wval_now;
    logic          done;
    int            j;

    // First requester at or after the round-robin pointer, cyclically
    always_comb begin
        pick  = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            if (!found && ch_req[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    assign rr_nxt = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = CMD;
            CMD:     if (done) state_nxt = IDLE;
                     else if (ack_now) state_nxt = DATA;
            DATA:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        active        = (state == CMD) || (state == DATA);
        biu.biu_req   = (state == CMD);
        ack_now       = (state == CMD) && biu.biu_ack;
        wval_now      = active && biu.biu_wval;
        ch_ack        = ack_now ? ch_gnt : '0;
        ch_wrd        = wval_now ? ch_gnt : '0;
        // A burst may finish on the ack cycle if its beats came early
        done          = active && (ack_seen || ack_now) &&
                        ((beat_cnt + LW'(wval_now)) == len_reg);
        biu.biu_adr   = '0;
        biu.biu_len   = '0;
        biu.biu_wdat  = '0;
        if (|ch_gnt) begin
            biu.biu_adr  = ch_adr[owner*AW +: AW];
            biu.biu_len  = ch_len[owner*LW +: LW];
            biu.biu_wdat = ch_wdat[owner*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_gnt   <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            len_reg  <= '0;
            beat_cnt <= '0;
            ack_seen <= 1'b0;
        end else if (state == IDLE) begin
            if (found) begin
                ch_gnt  <= {{(N-1){1'b0}}, 1'b1} << pick;
                owner   <= pick;
                len_reg <= ch_len[pick*LW +: LW];
            end
        end else if (done) begin
            ch_gnt   <= '0;
            beat_cnt <= '0;
            ack_seen <= 1'b0;
            rr_ptr   <= rr_nxt;
        end else begin
            if (wval_now) beat_cnt <= beat_cnt + 1'b1;
            if (ack_now)  ack_seen <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_dma_wc_arb.sv
// Directed bench for spi_dma_wc_arb: arbitration order, burst
// lengths, early beats, reset mid-burst and owner request drop.
module tb_spi_dma_wc_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int BL = 4;
    localparam int DW = 32;
    localparam int LW = BL + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        ch_req;
    logic [N*AW-1:0]     ch_adr;
    logic [N*LW-1:0]     ch_len;
    logic [N*DW-1:0]     ch_wdat;
    logic [N-1:0]        ch_ack;
    logic [N-1:0]        ch_wrd;
    logic [N-1:0]        ch_gnt;

    int vectors = 0;
    int miscompares = 0;
    int cnt;

    spi_dma_wc_arb_if #(.AW(AW), .BL(BL), .DW(DW)) biu ();

    spi_dma_wc_arb #(.N(N), .AW(AW), .BL(BL), .DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ch_req  (ch_req),
        .ch_adr  (ch_adr),
        .ch_len  (ch_len),
        .ch_wdat (ch_wdat),
        .ch_ack  (ch_ack),
        .ch_wrd  (ch_wrd),
        .ch_gnt  (ch_gnt),
        .biu     (biu.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ch_req = '0;
        biu.biu_ack = 1'b0;
        biu.biu_wval = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        ch_req = '0;
        ch_len = '0;
        biu.biu_ack = 1'b0;
        biu.biu_wval = 1'b0;
        for (int i = 0; i < N; i++) begin
            ch_adr[i*AW +: AW]  = 32'hA000_0000 + 32'(i);
            ch_wdat[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        end
        ch_adr[1*AW +: AW] = 32'h0000_1000;

        // reset state
        @(negedge clk);
        #1;
        chk("rst_gnt", 64'(ch_gnt), 0);
        chk("rst_req", 64'(biu.biu_req), 0);
        chk("rst_ack", 64'(ch_ack), 0);
        chk("rst_wrd", 64'(ch_wrd), 0);
        chk("rst_adr", 64'(biu.biu_adr), 0);
        step();
        rst_n = 1'b1;

        // single ch1 burst, len 4
        ch_len[1*LW +: LW] = 5'd4;
        ch_req = 4'b0010;
        #1;
        chk("t1_req_c0", 64'(biu.biu_req), 0);
        step();
        #1;
        chk("t1_req_c1", 64'(biu.biu_req), 1);
        chk("t1_gnt", 64'(ch_gnt), 4'b0010);
        chk("t1_adr", 64'(biu.biu_adr), 32'h1000);
        chk("t1_len", 64'(biu.biu_len), 4);
        biu.biu_ack = 1'b1;
        biu.biu_wval = 1'b1;
        #1;
        chk("t1_ack", 64'(ch_ack), 4'b0010);
        chk("t1_wdat", 64'(biu.biu_wdat), 32'hD000_0001);
        cnt = int'(ch_wrd[1]);
        step();
        ch_req = '0;
        biu.biu_ack = 1'b0;
        for (int b = 1; b < 4; b++) begin
            #1;
            chk("t1_dreq", 64'(biu.biu_req), 0);
            chk("t1_dgnt", 64'(ch_gnt), 4'b0010);
            cnt += int'(ch_wrd[1]);
            step();
        end
        biu.biu_wval = 1'b1;
        biu.biu_ack = 1'b1;
        #1;
        chk("t1_beats", 64'(cnt), 4);
        chk("t1_gnt_clr", 64'(ch_gnt), 0);
        chk("t1_idle_wrd", 64'(ch_wrd), 0);
        chk("t1_idle_ack", 64'(ch_ack), 0);
        biu.biu_wval = 1'b0;
        biu.biu_ack = 1'b0;

        // all channels, len 1: order 0,1,2,3,0 with one bubble
        do_reset();
        for (int i = 0; i < N; i++) ch_len[i*LW +: LW] = 5'd1;
        ch_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_bubble", 64'(biu.biu_req), 0);
            step();
            #1;
            chk("t2_req", 64'(biu.biu_req), 1);
            chk("t2_gnt", 64'(ch_gnt), 64'(1) << (k % 4));
            biu.biu_ack = 1'b1;
            biu.biu_wval = 1'b1;
            #1;
            chk("t2_ack", 64'(ch_ack), 64'(1) << (k % 4));
            chk("t2_wrd", 64'(ch_wrd), 64'(1) << (k % 4));
            step();
            biu.biu_ack = 1'b0;
            biu.biu_wval = 1'b0;
        end

        // len 16, first beat with ack
        do_reset();
        ch_len[0 +: LW] = 5'd16;
        ch_req = 4'b0001;
        step();
        cnt = 0;
        for (int b = 0; b < 16; b++) begin
            biu.biu_ack = (b == 0);
            biu.biu_wval = 1'b1;
            #1;
            if (b == 15) chk("t3_gnt_last", 64'(ch_gnt), 1);
            cnt += int'(ch_wrd[0]);
            step();
            ch_req = '0;
        end
        biu.biu_ack = 1'b0;
        biu.biu_wval = 1'b0;
        #1;
        chk("t3_beats", 64'(cnt), 16);
        chk("t3_gnt_clr", 64'(ch_gnt), 0);
        chk("t3_req", 64'(biu.biu_req), 0);

        // ch3, len 2, both beats before ack
        ch_len[3*LW +: LW] = 5'd2;
        ch_req = 4'b1000;
        step();
        #1;
        chk("t4_gnt", 64'(ch_gnt), 4'b1000);
        biu.biu_wval = 1'b1;
        #1;
        chk("t4_wrd0", 64'(ch_wrd), 4'b1000);
        chk("t4_noack", 64'(ch_ack), 0);
        step();
        #1;
        chk("t4_wrd1", 64'(ch_wrd), 4'b1000);
        step();
        biu.biu_wval = 1'b0;
        biu.biu_ack = 1'b1;
        ch_req = '0;
        #1;
        chk("t4_ack", 64'(ch_ack), 4'b1000);
        chk("t4_ack_wrd", 64'(ch_wrd), 0);
        step();
        biu.biu_ack = 1'b0;
        #1;
        chk("t4_gnt_clr", 64'(ch_gnt), 0);
        chk("t4_req", 64'(biu.biu_req), 0);

        // reset after 3 of 8 beats
        do_reset();
        ch_len[0 +: LW] = 5'd8;
        ch_req = 4'b0001;
        step();
        biu.biu_ack = 1'b1;
        biu.biu_wval = 1'b1;
        step();
        ch_req = '0;
        biu.biu_ack = 1'b0;
        step();
        step();
        biu.biu_wval = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_gnt", 64'(ch_gnt), 0);
        chk("t5_req", 64'(biu.biu_req), 0);
        step();
        rst_n = 1'b1;
        ch_req = 4'b1111;
        step();
        #1;
        chk("t5_rearb", 64'(ch_gnt), 4'b0001);

        // owner drops req, ch2 waits
        do_reset();
        ch_len[0 +: LW] = 5'd3;
        ch_len[2*LW +: LW] = 5'd2;
        ch_req = 4'b0001;
        step();
        biu.biu_ack = 1'b1;
        biu.biu_wval = 1'b1;
        ch_req = 4'b0100;
        #1;
        chk("t6_ack", 64'(ch_ack), 4'b0001);
        step();
        biu.biu_ack = 1'b0;
        #1;
        chk("t6_gnt", 64'(ch_gnt), 4'b0001);
        chk("t6_wrd", 64'(ch_wrd), 4'b0001);
        step();
        step();
        biu.biu_wval = 1'b0;
        #1;
        chk("t6_bubble_gnt", 64'(ch_gnt), 0);
        chk("t6_bubble_req", 64'(biu.biu_req), 0);
        step();
        #1;
        chk("t6_gnt2", 64'(ch_gnt), 4'b0100);
        chk("t6_req2", 64'(biu.biu_req), 1);
        chk("t6_len2", 64'(biu.biu_len), 2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
